// File: rtl/fp16_post_add_normalizer.sv
// Post-add normalize-and-pack stage for the binary16 adder path.
// Takes the raw significand sum/carry, sign and common aligned exponent, renormalizes the
// significand (right by one on carry, left one bit per cycle on cancellation), handles
// overflow to infinity, exact zero and underflow flush, and emits a packed binary16 word.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   in_valid_i     upstream presents a result
//   in_ready_o     stage can accept (IDLE only, never during reset)
//   in_sign_i      result sign
//   in_exp_i       common aligned exponent, biased
//   in_mant_i      adder sum, bit [FRAC_W] is the hidden-bit position
//   in_carry_i     adder carry-out
//   out_valid_o    out_result_o is valid
//   out_ready_i    downstream accepts
//   out_result_o   packed {sign, exp, frac}
//   busy_o         stage is not IDLE
module fp16_post_add_normalizer #(
  parameter int unsigned EXP_W  = 5,
  parameter int unsigned FRAC_W = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     in_sign_i,
  input  logic [EXP_W-1:0]         in_exp_i,
  input  logic [FRAC_W:0]          in_mant_i,
  input  logic                     in_carry_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [EXP_W+FRAC_W:0]    out_result_o,
  output logic                     busy_o
);

  localparam int unsigned MantW = FRAC_W + 1;
  localparam int unsigned ResW  = EXP_W + FRAC_W + 1;

  // Exponent arithmetic runs one bit wider so 31/underflow are detectable without wrap.
  localparam logic [EXP_W:0] ExpMax = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] ExpOne = (EXP_W + 1)'(1);

  typedef enum logic [1:0] {StIdle, StCheck, StShift, StPack} state_e;

  state_e              state_q, state_d;
  logic                sign_q, sign_d;
  logic                carry_q, carry_d;
  logic [EXP_W:0]      exp_q, exp_d;
  logic [MantW-1:0]    mant_q, mant_d;
  logic                out_valid_q, out_valid_d;
  logic [ResW-1:0]     out_result_q, out_result_d;
  logic [EXP_W:0]      exp_inc;

  assign exp_inc      = exp_q + ExpOne;
  assign in_ready_o   = (state_q == StIdle) && !rst_i;
  assign busy_o       = (state_q != StIdle);
  assign out_valid_o  = out_valid_q;
  assign out_result_o = out_result_q;

  // Special results (infinity, zero, flush) are encoded directly into exp/mant so the
  // PACK step is uniform: infinity = exp all-ones with zero fraction, zero = all zeros.
  always_comb begin
    state_d      = state_q;
    sign_d       = sign_q;
    carry_d      = carry_q;
    exp_d        = exp_q;
    mant_d       = mant_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid_i && in_ready_o) begin
          sign_d  = in_sign_i;
          carry_d = in_carry_i;
          exp_d   = {1'b0, in_exp_i};
          mant_d  = in_mant_i;
          state_d = StCheck;
        end
      end

      StCheck: begin
        state_d = StPack;
        if (exp_q == ExpMax) begin
          mant_d = '0;
        end else if (carry_q) begin
          // Right shift by one; the dropped LSB is truncated.
          mant_d = {1'b1, mant_q[MantW-1:1]};
          exp_d  = exp_inc;
          if (exp_inc == ExpMax) begin
            mant_d = '0;
          end
        end else if (mant_q == '0) begin
          exp_d = '0;
        end else if (mant_q[MantW-1]) begin
          if (exp_q == '0) begin
            mant_d = '0;
          end
        end else begin
          state_d = StShift;
        end
      end

      StShift: begin
        if (exp_q <= ExpOne) begin
          // No subnormals: flush once the exponent cannot go lower.
          exp_d   = '0;
          mant_d  = '0;
          state_d = StPack;
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - ExpOne;
          if (mant_q[MantW-2]) begin
            state_d = StPack;
          end
        end
      end

      StPack: begin
        if (!out_valid_q) begin
          out_valid_d  = 1'b1;
          out_result_d = {sign_q, exp_q[EXP_W-1:0], mant_q[FRAC_W-1:0]};
        end else if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      sign_q       <= 1'b0;
      carry_q      <= 1'b0;
      exp_q        <= '0;
      mant_q       <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
    end else begin
      state_q      <= state_d;
      sign_q       <= sign_d;
      carry_q      <= carry_d;
      exp_q        <= exp_d;
      mant_q       <= mant_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
    end
  end

endmodule

// File: tb/tb_fp16_post_add_normalizer.sv
module tb_fp16_post_add_normalizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [4:0]  in_exp = '0;
  logic [10:0] in_mant = '0;
  logic        in_carry = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp16_post_add_normalizer #(
    .EXP_W  (5),
    .FRAC_W (10)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_sign_i    (in_sign),
    .in_exp_i     (in_exp),
    .in_mant_i    (in_mant),
    .in_carry_i   (in_carry),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_result_o (out_result),
    .busy_o       (busy)
  );

  // Reference: treat {carry,mant} as an integer significand, normalize with closed-form
  // leading-one arithmetic, and derive the cycle count from the number of shifts needed.
  task automatic ref_model(input logic s, input int e, input int m, input logic c,
                           output logic [15:0] res, output int lat);
    int sig;
    int p;
    int k;
    logic [4:0] ef;
    lat = 2;
    if (e == 31) begin
      res = {s, 5'h1F, 10'h000};
    end else if (c) begin
      sig = (2048 + m) / 2;
      e = e + 1;
      ef = e[4:0];
      if (e >= 31) res = {s, 5'h1F, 10'h000};
      else         res = {s, ef, sig[9:0]};
    end else if (m == 0) begin
      res = {s, 15'h0000};
    end else begin
      p = -1;
      for (int i = 0; i < 11; i++) if (m[i]) p = i;
      k = 10 - p;
      if (k == 0) begin
        ef = e[4:0];
        res = (e == 0) ? {s, 15'h0000} : {s, ef, m[9:0]};
      end else if (e - 1 >= k) begin
        sig = m * (1 << k);
        ef = 5'(e - k);
        res = {s, ef, sig[9:0]};
        lat = 2 + k;
      end else begin
        res = {s, 15'h0000};
        lat = 2 + ((e > 1) ? e - 1 : 0) + 1;
      end
    end
  endtask

  // Presents one input, then counts edges after the accepting edge until out_valid.
  // lat = -1 means the stage never accepted or never produced a result.
  task automatic do_op(input logic s, input logic [4:0] e, input logic [10:0] m,
                       input logic c, output int lat, output logic [15:0] res);
    int n;
    lat = -1;
    res = 'x;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) return;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_carry = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Garbage on the inputs while busy must be ignored.
    in_sign  = 1'($urandom);
    in_exp   = 5'($urandom);
    in_mant  = 11'($urandom);
    in_carry = 1'($urandom);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        res = out_result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_result !== 16'h0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out_result=%h busy=%b required 0 0 0000 0",
               in_ready, out_valid, out_result, busy);
    end
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [15:0] exp_res [7] = '{16'h4000, 16'h3E00, 16'h9400, 16'h7C00, 16'h8000, 16'h0000,
                                 16'hFC00};
    int          exp_lat [7] = '{2, 2, 12, 2, 2, 5, 2};
    logic        vs [7] = '{0, 0, 1, 0, 1, 0, 1};
    logic [4:0]  ve [7] = '{15, 15, 15, 30, 10, 3, 31};
    logic [10:0] vm [7] = '{11'h000, 11'h600, 11'h001, 11'h7FE, 11'h000, 11'h040, 11'h5A5};
    logic        vc [7] = '{1, 0, 0, 1, 0, 0, 0};
    int lat;
    logic [15:0] res;
    for (int i = 0; i < 7; i++) begin
      do_op(vs[i], ve[i], vm[i], vc[i], lat, res);
      checks++;
      if (res !== exp_res[i] || lat !== exp_lat[i]) begin
        failures++;
        $display("FAIL directed_%0d: result=%h latency=%0d required %h latency=%0d",
                 i, res, lat, exp_res[i], exp_lat[i]);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL directed_%0d_handshake: out_valid=%b in_ready=%b required 0 1",
                 i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [15:0] res;
    do_op(1'b0, 5'd15, 11'h000, 1'b1, lat, res);
    checks++;
    if (res !== 16'h4000 || lat !== 2) begin
      failures++;
      $display("FAIL bp_result: result=%h latency=%0d required 4000 latency=2", res, lat);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_result !== 16'h4000 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d: out_valid=%b out_result=%h in_ready=%b required 1 4000 0",
                 i, out_valid, out_result, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    // in_valid was high across the handshake edge: nothing may be accepted there.
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: out_valid=%b busy=%b in_ready=%b required 0 0 1",
               out_valid, busy, in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic        s;
    logic [4:0]  e;
    logic [10:0] m;
    logic        c;
    logic [15:0] res;
    logic [15:0] want;
    int lat;
    int want_lat;
    int hold;
    for (int n = 0; n < 300; n++) begin
      s = 1'($urandom);
      e = 5'($urandom_range(0, 31));
      m = 11'($urandom_range(0, 2047) >> $urandom_range(0, 11));
      c = ($urandom_range(0, 3) == 0);
      ref_model(s, int'(e), int'(m), c, want, want_lat);
      do_op(s, e, m, c, lat, res);
      checks++;
      if (res !== want || lat !== want_lat) begin
        failures++;
        $display("FAIL random_%0d: s=%b e=%0d m=%h c=%b result=%h latency=%0d required %h latency=%0d",
                 n, s, e, m, c, res, lat, want, want_lat);
      end
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_result !== want || in_ready !== 1'b0) begin
          failures++;
          $display("FAIL random_hold_%0d: out_valid=%b out_result=%h in_ready=%b required 1 %h 0",
                   n, out_valid, out_result, in_ready, want);
        end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    logic [15:0] res;
    @(posedge clk); #1;
    in_sign  = 1'b1;
    in_exp   = 5'd15;
    in_mant  = 11'h001;
    in_carry = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_shift_busy: busy=%b required 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 16'h0000 || in_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_shift_reset: out_valid=%b out_result=%h in_ready=%b busy=%b required 0 0000 0 0",
               out_valid, out_result, in_ready, busy);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_shift_release: in_ready=%b required 1", in_ready);
    end
    do_op(1'b0, 5'd15, 11'h600, 1'b0, lat, res);
    checks++;
    if (res !== 16'h3E00 || lat !== 2) begin
      failures++;
      $display("FAIL after_reset_op: result=%h latency=%0d required 3e00 latency=2", res, lat);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
